// File: rtl/rv32_pkg.sv
// Shared RV32I fetch-path types: datapath widths, buffered fetch entry and fetch FSM states.
package rv32_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, execute redirect, decode valid/ready handshake and fault flag.
interface instr_fetch_unit_if;
    import rv32_pkg::*;

    logic            fetch_en;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            fault;

    modport master (
        input  fetch_en, imem_rdata, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_pc, out_instr, fault
    );

    modport slave (
        output fetch_en, imem_rdata, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_pc, out_instr, fault
    );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two {pc, instr} buffer with flush; a push into a full buffer is accepted when a pop frees the head.
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               din,
    output fetch_entry_t               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, wr_ptr == rd_ptr: the incoming word reuses the slot being popped.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC register, ROM addressing, redirect/fault FSM and arbitration into the fetch buffer.
module instr_fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic            fault;
    fetch_entry_t    din;
    fetch_entry_t    dout;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            out_valid;
    logic            pop;
    logic            flush;
    logic            push_req;
    logic            push_ok;

    assign out_valid = (state == RUN) && !empty;
    assign pop       = out_valid && bus.out_ready;
    // Any redirect while running clears the buffer; a misaligned one also parks the FSM in FAULT.
    assign flush     = (state == RUN) && bus.redirect_valid;
    assign push_req  = (state == RUN) && bus.fetch_en && !bus.redirect_valid;
    assign push_ok   = push_req && (!full || pop);
    assign din       = {fetch_pc, bus.imem_rdata};

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop),
        .flush (flush),
        .din   (din),
        .dout  (dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            fault    <= 1'b0;
        end else if (state == RUN) begin
            if (bus.redirect_valid) begin
                if (|bus.redirect_pc[1:0]) begin
                    state <= FAULT;
                    fault <= 1'b1;
                end else begin
                    fetch_pc <= bus.redirect_pc;
                end
            end else if (push_ok) begin
                fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));

    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = dout.pc;
    assign bus.out_instr = dout.instr;
    assign bus.fault     = fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit against a queue-based reference model.
module tb_instr_fetch_unit;
    import rv32_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ROM word k holds 0x13 + k.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h0000_0013 + (a >> 2);
    endfunction

    assign bus.imem_rdata = rom(bus.imem_addr);

    int checks = 0;
    int errors = 0;

    fetch_entry_t q[$];
    logic [31:0]  m_pc;
    bit           m_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc    = RESET_PC;
        m_fault = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; compares, then advances model across the posedge.
    task automatic cycle();
        bit exp_v;
        bit pop;
        exp_v = !m_fault && (q.size() != 0);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
        if (exp_v) begin
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("out_instr", bus.out_instr, q[0].instr);
        end
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("fault", 32'(bus.fault), 32'(m_fault));
        pop = exp_v && bus.out_ready;
        @(posedge clk);
        if (!m_fault && bus.redirect_valid) begin
            q.delete();
            if (bus.redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
            else m_pc = bus.redirect_pc;
        end else begin
            if (pop) void'(q.pop_front());
            if (!m_fault && bus.fetch_en && q.size() < DEPTH) begin
                q.push_back({m_pc, rom(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] saved;
        logic [31:0] tgt;

        bus.fetch_en       = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        model_reset();

        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming fetch, one instruction per cycle.
        bus.fetch_en  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) cycle();

        // Backpressure fills the buffer and freezes the PC.
        apply_reset();
        bus.out_ready = 1'b0;
        repeat (5) cycle();
        chk("stall_imem_addr", bus.imem_addr, 32'h8);
        chk("stall_out_pc", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        cycle();

        // Aligned redirect while head 0x4 is accepted.
        chk("redir_head", bus.out_pc, 32'h4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        cycle();
        bus.redirect_valid = 1'b0;
        chk("redir_bubble", 32'(bus.out_valid), 32'd0);
        chk("redir_imem_addr", bus.imem_addr, 32'h40);
        repeat (4) cycle();

        // Misaligned redirect, then asynchronous reset mid-fault.
        saved              = m_pc;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h42;
        cycle();
        bus.redirect_valid = 1'b0;
        chk("fault_rise", 32'(bus.fault), 32'd1);
        chk("fault_addr_hold", bus.imem_addr, saved);
        repeat (3) cycle();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_fault", 32'(bus.fault), 32'd0);
        chk("async_rst_addr", bus.imem_addr, RESET_PC);
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) cycle();

        // PC wrap at the top of the address space.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        cycle();
        bus.redirect_valid = 1'b0;
        repeat (5) cycle();

        // fetch_en low with a full buffer: drain, then resume at the frozen address.
        bus.out_ready = 1'b0;
        repeat (3) cycle();
        bus.fetch_en  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        chk("drained_valid", 32'(bus.out_valid), 32'd0);
        saved = bus.imem_addr;
        bus.fetch_en = 1'b1;
        cycle();
        chk("resume_addr_advance", bus.imem_addr, saved + 32'd4);
        repeat (3) cycle();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            bus.fetch_en       = ($urandom_range(0, 7) != 0);
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            tgt = $urandom() & 32'h0000_00FC;
            if ($urandom_range(0, 3) == 0) tgt = tgt | 32'hFFFF_FF00;
            if ($urandom_range(0, 9) == 0) tgt = tgt | 32'h0000_0002;
            bus.redirect_pc = tgt;
            if (m_fault && $urandom_range(0, 3) == 0) apply_reset();
            else cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage placed directly downstream of the instruction ROM in the RV32I core. Owns the program counter, drives the ROM word address, captures the returned instruction word, and buffers {pc, instr} pairs in a small FIFO. The decode stage drains the FIFO with a valid/ready handshake. Branch/jump redirects from execute flush the buffer and restart fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned
- DEPTH, 2, fetch buffer entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  fetch permitted; low holds the PC and suppresses pushes
- imem_addr  out  32  byte address to the ROM, equal to fetch_pc
- imem_rdata  in  32  ROM instruction word, combinational from imem_addr in the same cycle
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_pc  in  32  target byte address
- out_valid  out  1  buffer head holds a valid entry
- out_ready  in  1  decode accepts the head this cycle
- out_pc  out  32  PC of the head entry
- out_instr  out  32  instruction word of the head entry
- fault  out  1  sticky misaligned-redirect flag

## Operation
- FSM states:
  - RUN: normal fetch.
  - FAULT: entered when a redirect has redirect_pc[1:0] != 0. Exited only by reset.
- Pop: out_valid && out_ready. Removes the head.
- Push (RUN, fetch_en=1, no redirect): writes {fetch_pc, imem_rdata} and sets fetch_pc += 4, wrapping 32'hFFFF_FFFC→0.
  - Allowed when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
- Full buffer without a pop: no push, fetch_pc holds, imem_addr stable.
- Aligned redirect, priority over push:
  - A pop in the same cycle is honoured; decode has consumed that entry.
  - At the edge, the buffer is cleared (count=0, pointers reset) and fetch_pc = redirect_pc.
  - No push occurs in the redirect cycle.
- Misaligned redirect:
  - Buffer is cleared, fetch_pc is unchanged, state → FAULT, fault=1.
  - In FAULT: no pushes, out_valid=0, imem_addr holds.
- fetch_en=0: pops and redirects still function; only pushes and PC advance stop.
- Count arithmetic: log2(DEPTH)+1 bits. Pointers: log2(DEPTH) bits, natural wrap.
- Reset mid-operation clears everything asynchronously, regardless of pending handshakes.

## Timing
- Reset values:
  - fetch_pc = imem_addr = RESET_PC
  - count = 0, out_valid = 0, fault = 0, state RUN
  - buffer entries, out_pc and out_instr = 0
- out_valid, out_pc and out_instr are registered, driven from buffer state only. They carry no combinational path from out_ready or redirect_valid.
- Fetch latency: the push happens at the edge ending the cycle in which imem_addr = X. Entry X is visible at the output in the following cycle.
- After reset release with fetch_en=1: out_valid=1 with out_pc = RESET_PC in the cycle after the first edge.
- Redirect sampled at edge E:
  - Cycle after E: out_valid=0, imem_addr = target.
  - Target appears at the output after edge E+1 (one bubble cycle).
- Steady state with out_ready=1: one instruction per cycle, sequential PCs.
- fault rises in the cycle after the misaligned redirect edge.

## Structure
- Shared package rv32_pkg holds:
  - XLEN = 32 and INSTR_BYTES = 4
  - fetch_entry_t (packed struct {logic [31:0] pc; logic [31:0] instr;})
  - fetch_state_t enum {RUN, FAULT}
- Sub-module fetch_fifo:
  - Parameterised DEPTH.
  - Ports: push, pop, flush, din/dout of type fetch_entry_t, count, full, empty.
  - Async active-low reset.
  - Supports simultaneous push+pop when full.
- Top level holds the PC register, the FSM, and the push/redirect arbitration.

## Test plan
- Reset, fetch_en=1, out_ready=1, ROM word k = 32'h0000_0013 + k → out_pc sequence 0x0, 0x4, 0x8, … one per cycle, out_instr matches word index.
- out_ready=0 for 5 cycles → count saturates at 2, imem_addr holds at 0x8, out_pc stays 0x0. Then out_ready=1 → 0x0, 0x4, 0x8 with no gap or duplicate.
- Redirect to 0x40 while the head is 0x4 and out_ready=1 → 0x4 is accepted, one cycle with out_valid=0, then out_pc=0x40, 0x44.
- Redirect to 0x42 → fault=1 next cycle, out_valid stays 0, imem_addr unchanged. Assert rst_n=0 mid-fault → fault=0 and imem_addr=RESET_PC immediately (asynchronous).
- Redirect to 0xFFFF_FFF8 with out_ready=1 → out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- fetch_en dropped for 3 cycles with a full buffer and out_ready=1 → two entries drain, then out_valid=0 and imem_addr frozen. Re-enable → fetch resumes at the frozen address.
